icache_ifu_sa: RTL and testbench
================================

Name: icache_ifu_sa

Overview:
- Instruction-fetch unit with a parametrised N-way set-associative instruction cache using multi-word lines.
- Refills a line with one AXI4 INCR burst; hits are served from the cache.
- Sits between the PC-select/control logic and the IDU, and masters the AXI read channel toward MROM/SDRAM.
- Adds over the single-word direct-mapped generation: associativity, burst line refill, round-robin replacement, fence.i flush, bus-error reporting and exported performance counters.

Parameters:
- WAYS, 2, ways per set; power of two, 1..8.
- SETS, 16, sets; power of two, >=2.
- LINE_WORDS, 4, 32-bit words per line; power of two, 1..16.
- ID_W, 4, AXI ID width.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- if_allow_in  in  1  start a fetch at if_next_pc.
- if_next_pc  in  32  fetch address; word aligned.
- flush  in  1  fence.i: invalidate all lines.
- idu_ready  in  1  IDU accepts the instruction.
- idu_valid  out  1  instruction valid.
- idu_pc  out  32  PC of the instruction.
- idu_inst  out  32  instruction word.
- idu_fault  out  1  fetch bus error; idu_inst=0.
- io_master_arready  in  1.
- io_master_arvalid  out  1.
- io_master_araddr  out  32  line-aligned address.
- io_master_arid  out  ID_W.
- io_master_arlen  out  8  LINE_WORDS-1.
- io_master_arsize  out  3  3'b010.
- io_master_arburst  out  2  2'b01 (INCR).
- io_master_rvalid  in  1.
- io_master_rdata  in  32.
- io_master_rid  in  ID_W.
- io_master_rlast  in  1.
- io_master_rresp  in  2.
- io_master_rready  out  1.
- hit_count  out  32  lookup hits.
- miss_count  out  32  lookup misses.
- fetch_count  out  32  instructions delivered (accepted by IDU).

Behaviour:
- Address split:
  - offset = 2 bits + log2(LINE_WORDS) bits.
  - index = log2(SETS) bits.
  - tag = remaining bits.
- Reset (synchronous, active-high):
  - state=IDLE; all valid bits=0; all RR pointers=0; ID=0; counters=0; saved_pc=0.
  - arvalid=0, rready=0, idu_valid=0, idu_fault=0, idu_inst=0, idu_pc=0.
  - Reset mid-refill abandons the burst; no line is installed.
- IDLE:
  - If flush: clear all valid bits in that cycle and stay in IDLE.
  - Else if if_allow_in: latch saved_pc=if_next_pc and go to LOOKUP.
  - flush has priority over if_allow_in in the same cycle.
- flush arriving outside IDLE is held pending and applied on the next IDLE cycle. A line installed before the flush is applied is still invalidated.
- LOOKUP (1 cycle, tags compared across all ways):
  - Hit: hit_count++ once. idu_valid=1, idu_inst = word[offset] of the hit way. Stay in LOOKUP until idu_ready; then fetch_count++ and go to IDLE.
  - Miss: miss_count++, ID++, go to REQ.
  - Hit latency is 1 cycle after IDLE exits.
- REQ:
  - arvalid=1, araddr = saved_pc with the offset bits cleared.
  - araddr is held stable until arready; then go to REFILL.
- REFILL:
  - rready=1.
  - A beat with rid != current ID is consumed and ignored.
  - A matching beat is written to the victim way at word beat_cnt; beat_cnt++.
  - Any rresp != 0 sets a sticky error flag.
  - Termination: on rlast, or on beat LINE_WORDS-1 (whichever comes first).
    - No error: set the tag, set valid, advance that set's RR pointer (modulo WAYS), go to RESP.
    - Error: valid stays 0 and the pointer is unchanged; go to RESP with fault.
- Victim selection: the first invalid way (lowest index) if any; otherwise the RR pointer.
- RESP:
  - idu_valid=1, idu_inst = the fetched word at offset (0 on fault), idu_fault = error flag.
  - Hold until idu_ready; then fetch_count++, clear the error flag, go to IDLE.
- idu_pc = saved_pc in all states.
- Counters are 32-bit and wrap modulo 2^32.
- ID increments once per miss and wraps modulo 2^ID_W.
- No new request is issued before the previous burst completes (single outstanding transaction).

Decomposition:
- Package icache_pkg:
  - state enum {IDLE, LOOKUP, REQ, REFILL, RESP};
  - AXI constants (ARSIZE_WORD=3'b010, ARBURST_INCR=2'b01, RESP_OKAY=2'b00);
  - address-split width functions.
- Sub-module icache_array: tag, valid and data storage. It provides combinational multi-way lookup, a hit-way one-hot output, a word write port, a line install, and a flash invalidate.
- The FSM, victim selection and counters live in the top module.

Test Plan:
- Cold fetch at 0x20000000, WAYS=2, LINE_WORDS=4:
  - one AR with araddr=0x20000000, arlen=3, arsize=2, arburst=1;
  - 4 beats returned;
  - idu_inst = beat0;
  - miss_count=1, fetch_count=1.
- Then fetch 0x20000004, 0x20000008, 0x2000000C:
  - no AR issued;
  - each delivered 1 cycle after if_allow_in, with data = beats 1..3;
  - hit_count=3.
- Three distinct tags mapping to set 0 (0x20000000, 0x20000100, 0x20000200), then refetch 0x20000000:
  - the third miss evicts way 0 (RR);
  - the refetch misses (miss_count=4).
- Burst with beat 2 rresp=2'b10:
  - idu_fault=1, idu_inst=0;
  - a refetch of the same PC misses again and issues a new AR.
- flush pulsed during REFILL:
  - the current fetch completes normally;
  - the next fetch of the same line misses (a new AR is seen).
- idu_ready held low 5 cycles on a hit, plus a stray beat with rid=ID-1 during REFILL:
  - idu_valid stays high with inst/pc stable;
  - fetch_count increments by exactly 1;
  - the stray beat is not written to the line.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: shared FSM states, AXI constants and address-split widths for the set-associative IFU
package icache_pkg;
  typedef enum logic [2:0] {IDLE, LOOKUP, REQ, REFILL, RESP} state_t;
  localparam logic [2:0] ARSIZE_WORD = 3'b010;
  localparam logic [1:0] ARBURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  function automatic int off_w(input int lw);
    return 2 + $clog2(lw);
  endfunction
  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction
  function automatic int tag_w(input int sets, input int lw);
    return 32 - off_w(lw) - idx_w(sets);
  endfunction
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/icache_ifu_sa_if.sv
// icache_ifu_sa_if: AXI4 read address/data channel bundle between the IFU (master) and memory (slave)
//   ar*: address channel, r*: data channel; ID width set by ID_W
interface icache_ifu_sa_if #(parameter int ID_W = 4);
  logic arready;
  logic arvalid;
  logic [31:0] araddr;
  logic [ID_W-1:0] arid;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic rvalid;
  logic [31:0] rdata;
  logic [ID_W-1:0] rid;
  logic rlast;
  logic [1:0] rresp;
  logic rready;
  modport master(
    input arready, rvalid, rdata, rid, rlast, rresp,
    output arvalid, araddr, arid, arlen, arsize, arburst, rready
  );
  modport slave(
    output arready, rvalid, rdata, rid, rlast, rresp,
    input arvalid, araddr, arid, arlen, arsize, arburst, rready
  );
endinterface

// File: rtl/icache_array.sv
// icache_array: tag/valid/data storage with combinational all-way lookup, word write, line install and flash invalidate
//   rd_*: lookup set/tag/word -> hit_way (one-hot), hit, hit_data, set_valid
//   wr_*: single refill word write; line_*: per-way valid/tag update; inv_all: clear every valid bit
module icache_array import icache_pkg::*; #(
  parameter int WAYS = 2,
  parameter int SETS = 16,
  parameter int LINE_WORDS = 4,
  localparam int IW = idx_w(SETS),
  localparam int TW = tag_w(SETS, LINE_WORDS),
  localparam int BW = cnt_w(LINE_WORDS),
  localparam int WB = cnt_w(WAYS)
) (
  input  logic clock,
  input  logic reset,
  input  logic inv_all,
  input  logic [IW-1:0] rd_idx,
  input  logic [TW-1:0] rd_tag,
  input  logic [BW-1:0] rd_word,
  output logic [WAYS-1:0] hit_way,
  output logic hit,
  output logic [31:0] hit_data,
  output logic [WAYS-1:0] set_valid,
  input  logic wr_en,
  input  logic [WB-1:0] wr_way,
  input  logic [IW-1:0] wr_idx,
  input  logic [BW-1:0] wr_word,
  input  logic [31:0] wr_data,
  input  logic line_en,
  input  logic [WB-1:0] line_way,
  input  logic [IW-1:0] line_idx,
  input  logic [TW-1:0] line_tag,
  input  logic line_valid
);
  logic [WAYS-1:0] valid [SETS];
  logic [TW-1:0] tags [SETS][WAYS];
  logic [31:0] data [SETS][WAYS][LINE_WORDS];
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) valid[s] <= '0;
    end else if (inv_all) begin
      for (int s = 0; s < SETS; s++) valid[s] <= '0;
    end else if (line_en) begin
      valid[line_idx][line_way] <= line_valid;
    end
  end
  always_ff @(posedge clock) begin
    if (line_en && line_valid) tags[line_idx][line_way] <= line_tag;
    if (wr_en) data[wr_idx][wr_way][wr_word] <= wr_data;
  end
  always_comb begin
    hit_way = '0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_way[w] = valid[rd_idx][w] && (tags[rd_idx][w] == rd_tag);
      hit_data = hit_data | (hit_way[w] ? data[rd_idx][w][rd_word] : 32'h0);
    end
  end
  assign hit = |hit_way;
  assign set_valid = valid[rd_idx];
endmodule

// File: rtl/icache_ifu_sa.sv
// icache_ifu_sa: instruction-fetch unit with N-way set-associative I-cache and AXI4 INCR burst line refill
//   clock/reset: sync active-high reset; if_allow_in/if_next_pc: fetch request; flush: fence.i
//   idu_*: instruction handshake to the decoder; io_master: AXI read master; *_count: performance counters
module icache_ifu_sa import icache_pkg::*; #(
  parameter int WAYS = 2,
  parameter int SETS = 16,
  parameter int LINE_WORDS = 4,
  parameter int ID_W = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic if_allow_in,
  input  logic [31:0] if_next_pc,
  input  logic flush,
  input  logic idu_ready,
  output logic idu_valid,
  output logic [31:0] idu_pc,
  output logic [31:0] idu_inst,
  output logic idu_fault,
  icache_ifu_sa_if.master io_master,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic [31:0] fetch_count
);
  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int IW = idx_w(SETS);
  localparam int TW = tag_w(SETS, LINE_WORDS);
  localparam int BW = cnt_w(LINE_WORDS);
  localparam int WB = cnt_w(WAYS);
  state_t state;
  logic [31:0] saved_pc, line_word, resp_inst;
  logic [ID_W-1:0] cur_id;
  logic [BW-1:0] beat_cnt, word;
  logic [WB-1:0] victim, pick;
  logic [WB-1:0] rr [SETS];
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [WAYS-1:0] hit_way, set_valid;
  logic [31:0] hit_data;
  logic err, flush_pend, looked, resp_valid, resp_fault, hit, hit_now, beat, last, err_now, inv;
  assign idx = IW'(saved_pc >> OFF_W);
  assign tag = TW'(saved_pc >> (OFF_W + IW));
  assign word = BW'(saved_pc >> 2) & BW'(LINE_WORDS - 1);
  assign hit_now = (state == LOOKUP) && hit;
  // beats carrying a stale ID are accepted (rready is high) but otherwise dropped
  assign beat = (state == REFILL) && io_master.rvalid && (io_master.rid == cur_id);
  assign last = beat && (io_master.rlast || (beat_cnt == BW'(LINE_WORDS - 1)));
  assign err_now = err || (io_master.rresp != RESP_OKAY);
  assign inv = (state == IDLE) && (flush || flush_pend);
  // lowest-index invalid way wins; a full set falls back to the round-robin pointer
  always_comb begin
    pick = rr[idx];
    for (int w = WAYS - 1; w >= 0; w--) pick = set_valid[w] ? pick : WB'(w);
  end
  icache_array #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LINE_WORDS)) u_array (
    .clock(clock),
    .reset(reset),
    .inv_all(inv),
    .rd_idx(idx),
    .rd_tag(tag),
    .rd_word(word),
    .hit_way(hit_way),
    .hit(hit),
    .hit_data(hit_data),
    .set_valid(set_valid),
    .wr_en(beat),
    .wr_way(victim),
    .wr_idx(idx),
    .wr_word(beat_cnt),
    .wr_data(io_master.rdata),
    // a miss drops the victim's valid bit up front so an errored refill leaves it invalid
    .line_en(((state == LOOKUP) && !hit) || (last && !err_now)),
    .line_way(state == REFILL ? victim : pick),
    .line_idx(idx),
    .line_tag(tag),
    .line_valid(state == REFILL)
  );
  assign idu_valid = hit_now || resp_valid;
  assign idu_inst = hit_now ? hit_data : resp_inst;
  assign idu_fault = resp_fault;
  assign idu_pc = saved_pc;
  assign io_master.arvalid = (state == REQ);
  assign io_master.araddr = {saved_pc[31:OFF_W], OFF_W'(0)};
  assign io_master.arid = cur_id;
  assign io_master.arlen = 8'(LINE_WORDS - 1);
  assign io_master.arsize = ARSIZE_WORD;
  assign io_master.arburst = ARBURST_INCR;
  assign io_master.rready = (state == REFILL);
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      saved_pc <= '0;
      cur_id <= '0;
      beat_cnt <= '0;
      victim <= '0;
      err <= 1'b0;
      flush_pend <= 1'b0;
      looked <= 1'b0;
      line_word <= '0;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_inst <= '0;
      hit_count <= '0;
      miss_count <= '0;
      fetch_count <= '0;
      for (int s = 0; s < SETS; s++) rr[s] <= '0;
    end else begin
      flush_pend <= (state != IDLE) && (flush || flush_pend);
      if (idu_valid && idu_ready) fetch_count <= fetch_count + 32'd1;
      case (state)
        IDLE: begin
          looked <= 1'b0;
          if (!inv && if_allow_in) begin
            saved_pc <= if_next_pc;
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (!looked) hit_count <= hit_count + 32'd1;
            looked <= 1'b1;
            if (idu_ready) state <= IDLE;
          end else begin
            miss_count <= miss_count + 32'd1;
            cur_id <= cur_id + 1'b1;
            victim <= pick;
            beat_cnt <= '0;
            err <= 1'b0;
            line_word <= '0;
            state <= REQ;
          end
        end
        REQ: state <= io_master.arready ? REFILL : REQ;
        REFILL: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
            err <= err_now;
            if (beat_cnt == word) line_word <= io_master.rdata;
            if (last) begin
              if (!err_now) rr[idx] <= (rr[idx] == WB'(WAYS - 1)) ? '0 : rr[idx] + 1'b1;
              resp_valid <= 1'b1;
              resp_fault <= err_now;
              resp_inst <= err_now ? 32'h0 : (beat_cnt == word ? io_master.rdata : line_word);
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (idu_ready) begin
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_inst <= '0;
            err <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_ifu_sa.sv
// tb_icache_ifu_sa: scoreboard bench for icache_ifu_sa with a behavioural AXI burst slave
module tb_icache_ifu_sa;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic fault;
  } exp_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic if_allow_in = 1'b0;
  logic [31:0] if_next_pc = '0;
  logic flush = 1'b0;
  logic idu_ready = 1'b1;
  logic idu_valid, idu_fault;
  logic [31:0] idu_pc, idu_inst, hit_count, miss_count, fetch_count;
  icache_ifu_sa_if #(.ID_W(4)) io ();
  icache_ifu_sa #(.WAYS(2), .SETS(16), .LINE_WORDS(4), .ID_W(4)) dut (
    .clock(clock),
    .reset(reset),
    .if_allow_in(if_allow_in),
    .if_next_pc(if_next_pc),
    .flush(flush),
    .idu_ready(idu_ready),
    .idu_valid(idu_valid),
    .idu_pc(idu_pc),
    .idu_inst(idu_inst),
    .idu_fault(idu_fault),
    .io_master(io),
    .hit_count(hit_count),
    .miss_count(miss_count),
    .fetch_count(fetch_count)
  );
  always #5 clock = ~clock;
  int vectors = 0;
  int miscompares = 0;
  int ar_cnt = 0;
  logic [31:0] ar_addr = '0;
  logic [3:0] ar_id = '0;
  logic [7:0] ar_len = '0;
  logic [2:0] ar_size = '0;
  logic [1:0] ar_burst = '0;
  bit stray = 1'b0;
  int err_beat = 99;
  exp_t sb[$];
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0FFEE11;
  endfunction
  initial begin
    io.arready = 1'b1;
    io.rvalid = 1'b0;
    io.rdata = '0;
    io.rid = '0;
    io.rlast = 1'b0;
    io.rresp = 2'b00;
    forever begin
      @(negedge clock);
      if (!reset && io.arvalid) begin
        ar_cnt++;
        ar_addr = io.araddr;
        ar_id = io.arid;
        ar_len = io.arlen;
        ar_size = io.arsize;
        ar_burst = io.arburst;
        @(posedge clock);
        #1;
        for (int b = stray ? -1 : 0; b <= int'(ar_len); b++) begin
          io.rvalid = 1'b1;
          io.rid = b < 0 ? ar_id - 1'b1 : ar_id;
          io.rdata = b < 0 ? 32'hDEADBEEF : mem(ar_addr + 32'(4 * b));
          io.rresp = (b == err_beat) ? 2'b10 : 2'b00;
          io.rlast = (b == int'(ar_len));
          for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            if (io.rready) break;
          end
          @(posedge clock);
          #1;
        end
        io.rvalid = 1'b0;
        io.rlast = 1'b0;
        io.rresp = 2'b00;
      end
    end
  end
  task automatic start_fetch(input logic [31:0] pc, input logic fault);
    sb.push_back({pc, fault ? 32'h0 : mem(pc), fault});
    if_allow_in = 1'b1;
    if_next_pc = pc;
    @(posedge clock);
    #1;
    if_allow_in = 1'b0;
  endtask
  task automatic wait_deliver(output exp_t got, output int lat);
    lat = 0;
    got = '0;
    while (1) begin
      @(negedge clock);
      if (idu_valid) break;
      lat++;
      if (lat >= 300) begin
        vectors++;
        miscompares++;
        $display("FAIL deliver_timeout got no idu_valid want idu_valid within 300 cycles");
        return;
      end
    end
    got = {idu_pc, idu_inst, idu_fault};
  endtask
  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    vectors++;
    if ({idu_valid, idu_fault, idu_inst, idu_pc} !== 66'h0) begin
      miscompares++;
      $display("FAIL reset_idu got v=%b f=%b inst=%h pc=%h want all zero", idu_valid, idu_fault, idu_inst, idu_pc);
    end
    vectors++;
    if ({io.arvalid, io.rready} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_axi got arvalid=%b rready=%b want 0 0", io.arvalid, io.rready);
    end
    vectors++;
    if ({hit_count, miss_count, fetch_count} !== 96'h0) begin
      miscompares++;
      $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", hit_count, miss_count, fetch_count);
    end
    @(posedge clock);
    #1;
  endtask
  task automatic test_cold();
    exp_t g, e;
    int lat;
    int a0 = ar_cnt;
    start_fetch(32'h2000_0000, 1'b0);
    wait_deliver(g, lat);
    e = sb.pop_front();
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL cold_word got %h want %h", g, e);
    end
    vectors++;
    if ({ar_cnt - a0, ar_addr} !== {32'd1, 32'h2000_0000}) begin
      miscompares++;
      $display("FAIL cold_ar got count=%0d addr=%h want 1 20000000", ar_cnt - a0, ar_addr);
    end
    vectors++;
    if ({ar_len, ar_size, ar_burst, ar_id} !== {8'd3, 3'd2, 2'd1, 4'd1}) begin
      miscompares++;
      $display("FAIL cold_ar_fields got len=%0d size=%0d burst=%0d id=%0d want 3 2 1 1", ar_len, ar_size, ar_burst, ar_id);
    end
    @(posedge clock);
    #1;
    vectors++;
    if ({hit_count, miss_count, fetch_count} !== {32'd0, 32'd1, 32'd1}) begin
      miscompares++;
      $display("FAIL cold_counters got h=%0d m=%0d f=%0d want 0 1 1", hit_count, miss_count, fetch_count);
    end
  endtask
  task automatic test_hits();
    exp_t g, e;
    int lat;
    int a0 = ar_cnt;
    for (int i = 1; i <= 3; i++) begin
      start_fetch(32'h2000_0000 + 32'(4 * i), 1'b0);
      wait_deliver(g, lat);
      e = sb.pop_front();
      vectors++;
      if (g !== e || lat != 0) begin
        miscompares++;
        $display("FAIL hit_word%0d got %h lat=%0d want %h lat=0", i, g, lat, e);
      end
      @(posedge clock);
      #1;
    end
    vectors++;
    if ({ar_cnt - a0, hit_count} !== {32'd0, 32'd3}) begin
      miscompares++;
      $display("FAIL hit_counts got ar=%0d hits=%0d want 0 3", ar_cnt - a0, hit_count);
    end
  endtask
  task automatic test_rr();
    exp_t g, e;
    int lat;
    logic [31:0] pcs [3] = '{32'h2000_0100, 32'h2000_0200, 32'h2000_0000};
    int a0 = ar_cnt;
    for (int i = 0; i < 3; i++) begin
      start_fetch(pcs[i], 1'b0);
      wait_deliver(g, lat);
      e = sb.pop_front();
      vectors++;
      if (g !== e || ar_cnt != a0 + i + 1) begin
        miscompares++;
        $display("FAIL rr_miss%0d got %h ar=%0d want %h ar=%0d", i, g, ar_cnt - a0, e, i + 1);
      end
      @(posedge clock);
      #1;
    end
    vectors++;
    if (miss_count !== 32'd4) begin
      miscompares++;
      $display("FAIL rr_miss_count got %0d want 4", miss_count);
    end
    start_fetch(32'h2000_0204, 1'b0);
    wait_deliver(g, lat);
    e = sb.pop_front();
    vectors++;
    if (g !== e || lat != 0 || ar_cnt != a0 + 3) begin
      miscompares++;
      $display("FAIL rr_survivor got %h lat=%0d ar=%0d want %h lat=0 ar=3", g, lat, ar_cnt - a0, e);
    end
    @(posedge clock);
    #1;
  endtask
  task automatic test_fault();
    exp_t g, e;
    int lat;
    int a0 = ar_cnt;
    err_beat = 2;
    start_fetch(32'h2000_0300, 1'b1);
    wait_deliver(g, lat);
    e = sb.pop_front();
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL fault_resp got %h want %h", g, e);
    end
    @(posedge clock);
    #1;
    err_beat = 99;
    start_fetch(32'h2000_0300, 1'b0);
    wait_deliver(g, lat);
    e = sb.pop_front();
    vectors++;
    if (g !== e || ar_cnt != a0 + 2) begin
      miscompares++;
      $display("FAIL fault_refetch got %h ar=%0d want %h ar=2", g, ar_cnt - a0, e);
    end
    @(posedge clock);
    #1;
  endtask
  task automatic test_flush();
    exp_t g, e;
    int lat;
    int a0 = ar_cnt;
    start_fetch(32'h2000_0400, 1'b0);
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (io.rready) break;
    end
    @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    wait_deliver(g, lat);
    e = sb.pop_front();
    vectors++;
    if (g !== e || ar_cnt != a0 + 1) begin
      miscompares++;
      $display("FAIL flush_current got %h ar=%0d want %h ar=1", g, ar_cnt - a0, e);
    end
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    start_fetch(32'h2000_0404, 1'b0);
    wait_deliver(g, lat);
    e = sb.pop_front();
    vectors++;
    if (g !== e || ar_cnt != a0 + 2) begin
      miscompares++;
      $display("FAIL flush_refetch got %h ar=%0d want %h ar=2", g, ar_cnt - a0, e);
    end
    @(posedge clock);
    #1;
  endtask
  task automatic test_back_to_back();
    exp_t g, e;
    int lat;
    logic [31:0] h0, f0;
    stray = 1'b1;
    start_fetch(32'h2000_0500, 1'b0);
    wait_deliver(g, lat);
    e = sb.pop_front();
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL stray_word got %h want %h", g, e);
    end
    @(posedge clock);
    #1;
    stray = 1'b0;
    h0 = hit_count;
    f0 = fetch_count;
    idu_ready = 1'b0;
    start_fetch(32'h2000_0508, 1'b0);
    wait_deliver(g, lat);
    e = sb.pop_front();
    vectors++;
    if (g !== e || lat != 0) begin
      miscompares++;
      $display("FAIL stall_first got %h lat=%0d want %h lat=0", g, lat, e);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      vectors++;
      if ({idu_valid, idu_pc, idu_inst} !== {1'b1, e.pc, e.inst}) begin
        miscompares++;
        $display("FAIL stall_hold%0d got v=%b pc=%h inst=%h want 1 %h %h", i, idu_valid, idu_pc, idu_inst, e.pc, e.inst);
      end
    end
    @(posedge clock);
    #1;
    idu_ready = 1'b1;
    @(posedge clock);
    #1;
    vectors++;
    if ({fetch_count - f0, hit_count - h0} !== {32'd1, 32'd1}) begin
      miscompares++;
      $display("FAIL stall_counts got fetch+%0d hit+%0d want 1 1", fetch_count - f0, hit_count - h0);
    end
    for (int i = 0; i < 2; i++) begin
      start_fetch(i == 0 ? 32'h2000_0504 : 32'h2000_050C, 1'b0);
      wait_deliver(g, lat);
      e = sb.pop_front();
      vectors++;
      if (g !== e || lat != 0) begin
        miscompares++;
        $display("FAIL b2b_hit%0d got %h lat=%0d want %h lat=0", i, g, lat, e);
      end
      @(posedge clock);
      #1;
    end
  endtask
  initial begin
    test_reset();
    test_cold();
    test_hits();
    test_rr();
    test_fault();
    test_flush();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog got no completion want finish before 500000");
    $fatal(1, "watchdog");
  end
endmodule
